// File: rtl/factorial_pkg.sv
// Shared types and constants for the iterative factorial engine.
// Holds the control-state encoding and the error-code values.
package factorial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    WAIT,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;

endpackage

// File: rtl/fact_mult.sv
// W x W -> 2W multiplier for the factorial engine: either a single-cycle
// array multiply or a shift-add unit that retires one multiplier bit per cycle.
module fact_mult #(
  parameter int W   = 32,
  parameter bit SEQ = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_product,
  output logic           o_done
);

  generate
    if (SEQ == 1'b0) begin : g_comb
      logic w_unused;
      assign o_product = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
      assign o_done    = 1'b1;
      assign w_unused  = &{1'b0, i_clk, i_rst_n, i_start};
    end else begin : g_seq
      localparam int BW = $clog2(W + 1);

      logic [2*W-1:0] r_mcand;
      logic [2*W-1:0] r_prod;
      logic [W-1:0]   r_mplier;
      logic [BW-1:0]  r_bits;
      logic           r_run;
      logic [2*W-1:0] w_addend;

      // The final partial sum is exposed combinationally so the caller can
      // capture the full product on the same edge that retires the last bit.
      assign w_addend  = r_mplier[0] ? r_mcand : '0;
      assign o_product = r_prod + w_addend;
      assign o_done    = r_run && (r_bits == BW'(1));

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_mcand  <= '0;
          r_prod   <= '0;
          r_mplier <= '0;
          r_bits   <= '0;
          r_run    <= 1'b0;
        end else if (i_start) begin
          r_mcand  <= {{W{1'b0}}, i_a};
          r_prod   <= '0;
          r_mplier <= i_b;
          r_bits   <= BW'(W);
          r_run    <= 1'b1;
        end else if (r_run) begin
          r_prod   <= o_product;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_bits   <= r_bits - BW'(1);
          if (r_bits == BW'(1)) r_run <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/factorial_engine.sv
// Iterative N! unit with start/done handshake, operand range check and
// overflow detection on the full double-width product.
module factorial_engine
  import factorial_pkg::*;
#(
  parameter int N_W      = 4,
  parameter int R_W      = 32,
  parameter int MAX_N    = 12,
  parameter bit MULT_SEQ = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_go,
  input  logic [N_W-1:0] i_n,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_error,
  output logic [1:0]     o_errCode,
  output logic [R_W-1:0] o_result
);

  state_t r_state;
  state_t w_stateNext;

  logic [N_W-1:0]   r_cnt;
  logic [R_W-1:0]   r_acc;
  logic [R_W-1:0]   r_result;
  logic [1:0]       r_errCode;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic [2*R_W-1:0] w_prod;
  logic             w_multDone;
  logic             w_multStart;
  logic             w_ovf;
  logic             w_rangeErr;
  logic             w_cntGt1;
  logic             w_prodReady;

  assign w_rangeErr  = {{(32-N_W){1'b0}}, i_n} > 32'(MAX_N);
  assign w_cntGt1    = r_cnt > N_W'(1);
  assign w_ovf       = |w_prod[2*R_W-1:R_W];
  assign w_multStart = (r_state == MUL) && w_cntGt1;
  assign w_prodReady = ((r_state == MUL) && w_cntGt1 && !MULT_SEQ) ||
                       ((r_state == WAIT) && w_multDone);

  fact_mult #(
    .W   (R_W),
    .SEQ (MULT_SEQ)
  ) u_mult (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_multStart),
    .i_a       (r_acc),
    .i_b       ({{(R_W-N_W){1'b0}}, r_cnt}),
    .o_product (w_prod),
    .o_done    (w_multDone)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: if (i_go) w_stateNext = w_rangeErr ? ERR : MUL;
      MUL: begin
        if (!w_cntGt1)     w_stateNext = DONE;
        else if (MULT_SEQ) w_stateNext = WAIT;
        else if (w_ovf)    w_stateNext = ERR;
      end
      WAIT: if (w_multDone) w_stateNext = w_ovf ? ERR : MUL;
      DONE, ERR: w_stateNext = IDLE;
      default:   w_stateNext = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up
  // exactly with the DONE/ERR cycles without any input-to-output path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_errCode <= ERR_NONE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_busy  <= (w_stateNext != IDLE);
      r_done  <= (w_stateNext == DONE);
      r_error <= (w_stateNext == ERR);
      if ((r_state == IDLE) && i_go) begin
        if (w_rangeErr) begin
          r_errCode <= ERR_RANGE;
          r_result  <= '0;
        end else begin
          r_cnt     <= i_n;
          r_acc     <= R_W'(1);
          r_errCode <= ERR_NONE;
        end
      end
      if ((r_state == MUL) && !w_cntGt1) r_result <= r_acc;
      if (w_prodReady) begin
        if (w_ovf) begin
          r_errCode <= ERR_OVF;
          r_result  <= '0;
        end else begin
          r_acc <= w_prod[R_W-1:0];
          r_cnt <= r_cnt - N_W'(1);
        end
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_error   = r_error;
  assign o_errCode = r_errCode;
  assign o_result  = r_result;

endmodule

// File: tb/tb_factorial_engine.sv
// Self-checking bench for factorial_engine: three instances (default, MAX_N=15,
// shift-add multiplier) checked against an arithmetic model of N! timing and results.
module tb_factorial_engine;

  logic        clk = 1'b0;
  logic        rstN;
  logic        go      [3];
  logic [3:0]  nIn     [3];
  logic        busy    [3];
  logic        done    [3];
  logic        error   [3];
  logic [1:0]  errCode [3];
  logic [31:0] result  [3];

  int maxN   [3] = '{12, 15, 12};
  int perMul [3] = '{1, 1, 33};

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  factorial_engine dut0 (
    .i_clk(clk), .i_rst_n(rstN), .i_go(go[0]), .i_n(nIn[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_error(error[0]),
    .o_errCode(errCode[0]), .o_result(result[0])
  );

  factorial_engine #(.MAX_N(15)) dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_go(go[1]), .i_n(nIn[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_error(error[1]),
    .o_errCode(errCode[1]), .o_result(result[1])
  );

  factorial_engine #(.MULT_SEQ(1'b1)) dut2 (
    .i_clk(clk), .i_rst_n(rstN), .i_go(go[2]), .i_n(nIn[2]),
    .o_busy(busy[2]), .o_done(done[2]), .o_error(error[2]),
    .o_errCode(errCode[2]), .o_result(result[2])
  );

  // Reference: plain running product of n, n-1, ..., 2 in 64 bits; each
  // multiply costs perMul cycles, the terminal pulse lands one or two after.
  function automatic void model(input int d, input int n, output int kind,
                                output int cyc, output logic [31:0] res,
                                output logic [1:0] code);
    longint unsigned p;
    int k;
    if (n > maxN[d]) begin
      kind = 1; cyc = 1; res = 32'd0; code = 2'd1;
      return;
    end
    p = 64'd1;
    k = 0;
    for (int m = n; m >= 2; m--) begin
      p = p * longint'(m);
      k++;
      if (p >= 64'h1_0000_0000) begin
        kind = 1; cyc = k * perMul[d] + 1; res = 32'd0; code = 2'd2;
        return;
      end
    end
    kind = 0; cyc = k * perMul[d] + 2; res = p[31:0]; code = 2'd0;
  endfunction

  // Called at a negedge while the instance is idle; returns at the negedge
  // of the cycle in which Done/Error has fallen, so calls chain back-to-back.
  task automatic runOp(input int d, input int n, input bit noisy, input string name);
    int kind, expCyc, c;
    logic [31:0] expRes;
    logic [1:0]  expCode;
    bit seen;
    model(d, n, kind, expCyc, expRes, expCode);
    go[d]  = 1'b1;
    nIn[d] = 4'(n);
    @(posedge clk);
    #1;
    go[d]  = 1'b0;
    nIn[d] = 4'($urandom);
    seen = 1'b0;
    c = 0;
    while (!seen && c < expCyc + 20) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        nChecks++;
        if (busy[d] !== 1'b1) begin
          nFails++;
          $display("[TB] FAIL %s busy_c1: got %b expected 1", name, busy[d]);
        end
      end
      if (done[d] === 1'b1 || error[d] === 1'b1) begin
        seen = 1'b1;
        go[d] = 1'b0;
      end else if (noisy) begin
        go[d]  = 1'($urandom);
        nIn[d] = 4'($urandom);
      end
    end
    go[d] = 1'b0;
    nChecks++;
    if (!seen) begin
      nFails++;
      $display("[TB] FAIL %s timeout: no Done/Error after %0d cycles, expected cycle %0d", name, c, expCyc);
      return;
    end
    nChecks++;
    if (c != expCyc) begin
      nFails++;
      $display("[TB] FAIL %s cycle: got %0d expected %0d", name, c, expCyc);
    end
    nChecks++;
    if (done[d] !== (kind == 0) || error[d] !== (kind == 1)) begin
      nFails++;
      $display("[TB] FAIL %s pulse: got done=%b error=%b expected done=%0d error=%0d",
               name, done[d], error[d], kind == 0, kind == 1);
    end
    nChecks++;
    if (result[d] !== expRes) begin
      nFails++;
      $display("[TB] FAIL %s result: got %0d expected %0d", name, result[d], expRes);
    end
    nChecks++;
    if (errCode[d] !== expCode) begin
      nFails++;
      $display("[TB] FAIL %s errCode: got %0d expected %0d", name, errCode[d], expCode);
    end
    @(negedge clk);
    nChecks++;
    if (busy[d] !== 1'b0 || done[d] !== 1'b0 || error[d] !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL %s release: got busy=%b done=%b error=%b expected all 0",
               name, busy[d], done[d], error[d]);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    for (int d = 0; d < 3; d++) begin
      go[d]  = 1'b0;
      nIn[d] = 4'd0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      nChecks++;
      if ({busy[d], done[d], error[d], errCode[d], result[d]} !== 37'd0) begin
        nFails++;
        $display("[TB] FAIL reset dut%0d: got busy=%b done=%b error=%b code=%0d result=%0d expected all 0",
                 d, busy[d], done[d], error[d], errCode[d], result[d]);
      end
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    runOp(0, 5, 1'b0, "n5");
  endtask

  task automatic test_back_to_back();
    runOp(0, 0, 1'b0, "n0");
    runOp(0, 1, 1'b0, "n1_b2b");
    runOp(0, 2, 1'b0, "n2_b2b");
  endtask

  task automatic test_range();
    runOp(0, 12, 1'b0, "n12");
    nChecks++;
    if (result[0] !== 32'h1C8C_FC00) begin
      nFails++;
      $display("[TB] FAIL n12_const: got %h expected 1c8cfc00", result[0]);
    end
    runOp(0, 13, 1'b0, "n13_range");
    runOp(0, 15, 1'b0, "n15_range");
  endtask

  task automatic test_overflow();
    runOp(1, 12, 1'b0, "ovf_n12");
    runOp(1, 13, 1'b0, "ovf_n13");
    runOp(1, 15, 1'b0, "ovf_n15");
  endtask

  task automatic test_seq_mult();
    runOp(2, 5, 1'b1, "seq_n5_noisy");
    runOp(2, 1, 1'b0, "seq_n1");
    runOp(2, 13, 1'b0, "seq_range");
  endtask

  task automatic test_random();
    int d, n;
    for (int i = 0; i < 14; i++) begin
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(0, 15));
      runOp(d, n, 1'($urandom), $sformatf("rnd%0d_d%0d_n%0d", i, d, n));
    end
    for (int i = 0; i < 2; i++) begin
      n = int'($urandom_range(0, 7));
      runOp(2, n, 1'b1, $sformatf("rnd_seq%0d_n%0d", i, n));
    end
  endtask

  task automatic test_reset_midrun();
    runOp(0, 4, 1'b0, "pre_reset_n4");
    go[0]  = 1'b1;
    nIn[0] = 4'd10;
    @(posedge clk);
    #1;
    go[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    nChecks++;
    if ({busy[0], done[0], error[0], errCode[0], result[0]} !== 37'd0) begin
      nFails++;
      $display("[TB] FAIL async_reset: got busy=%b done=%b error=%b code=%0d result=%0d expected all 0",
               busy[0], done[0], error[0], errCode[0], result[0]);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    runOp(0, 3, 1'b0, "post_reset_n3");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_range();
    test_overflow();
    test_seq_mult();
    test_random();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/factorial_engine.md
# factorial_engine

Parametrised iterative factorial unit: computes N! for an N_W-bit operand into an R_W-bit result, with range checking and runtime overflow detection. It combines its control FSM and datapath (count-down register, product register, multiplier) in one block. A start/done handshake connects it to a host FSM or bus wrapper. A mode parameter selects between a single-cycle multiplier and a shift-add sequential multiplier, for area-constrained builds.

## Interface
- N_W, 4, operand width.
- R_W, 32, result width.
- MAX_N, 12, largest accepted operand; 12! fits in 32 bits.
- MULT_SEQ, 0, 0 = single-cycle multiply, 1 = shift-add multiply (R_W cycles per product).
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Go  in  1  start request; sampled only in IDLE.
- N  in  N_W  operand; captured on the accepting edge.
- Busy  out  1  high from the accepting edge until the DONE/ERR state is left.
- Done  out  1  one-cycle pulse; Result valid.
- Error  out  1  one-cycle pulse; ErrCode valid.
- ErrCode  out  2  0 none, 1 range (N > MAX_N), 2 overflow; holds until the next accept.
- Result  out  R_W  last product; holds until the next accept.

## Operation
- Reset values: state IDLE, Busy=0, Done=0, Error=0, ErrCode=0, Result=0, internal CNT=0, ACC=0.
- IDLE, Go=1, N>MAX_N: go to ERR; ErrCode<=1; Result<=0.
- IDLE, Go=1, N≤MAX_N: go to MUL; CNT<=N; ACC<=1; ErrCode<=0.
- MUL, CNT>1: ACC<=ACC*CNT and CNT<=CNT-1.
  - MULT_SEQ=0: completes in 1 cycle.
  - MULT_SEQ=1: go to WAIT for R_W cycles, then return to MUL.
- MUL, CNT≤1: go to DONE; Result<=ACC.
- Overflow check: the full 2·R_W product is formed. Any nonzero upper R_W bits send the FSM to ERR with ErrCode<=2 and Result<=0. No further multiplies occur.
- DONE: Done=1 for one cycle, then IDLE.
- ERR: Error=1 for one cycle, then IDLE.
- Go outside IDLE is ignored. It is not queued.
- N is don't-care except on the accepting edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- RST_N low in any state aborts the operation immediately and returns everything to its reset values. After release, the first cycle is IDLE.

## Timing
- The accepting edge is cycle 0. Busy rises after that edge.
- MULT_SEQ=0: Done high in cycle n+1 for n≥2. For n∈{0,1}, Done high in cycle 2.
- MULT_SEQ=1: Done high in cycle (n−1)·(R_W+1)+2 for n≥2. For n∈{0,1}, Done high in cycle 2.
- Range error: Error high in cycle 1.
- Overflow error: Error high in the cycle after the overflowing multiply completes.
- Busy falls in the same cycle that Done or Error falls. The next Go can be accepted in that cycle (back-to-back).

## Structure
- Shared package factorial_pkg holds:
  - the state encoding: IDLE, MUL, WAIT, DONE, ERR;
  - the ErrCode constants: ERR_NONE, ERR_RANGE, ERR_OVF.
- Sub-module fact_mult: R_W×R_W→2·R_W multiplier.
  - Ports: start and done.
  - MULT_SEQ=0: combinational, done tied high.
  - MULT_SEQ=1: shift-add, one bit per cycle; done pulses after R_W cycles.
- The top level contains the FSM, CNT, ACC and the output registers.

## Test plan
- Defaults, Go with N=5:
  - Busy rises after the accepting edge.
  - Done pulse in cycle 6.
  - Result=120, ErrCode=0.
- N=0 then N=1, back-to-back:
  - Each gives a Done pulse in cycle 2 with Result=1.
  - The second Go is accepted in the cycle the first Done falls.
- N=12 → Result=0x1C8CFC00 (479001600), Done in cycle 13. Then N=13 → Error in cycle 1, ErrCode=1, Result=0, no Done.
- MAX_N=15, R_W=32, N=13:
  - The multiply 13·12!=6227020800 overflows.
  - Error pulse, ErrCode=2, Result=0.
- MULT_SEQ=1, N=5 → Result=120, Done in cycle 4·33+2=134. Go pulses while Busy are ignored, and Result is unchanged.
- N=10 run, RST_N asserted in cycle 4:
  - All outputs are at their reset values in the same cycle, without waiting for CLK.
  - After release, N=3 gives Result=6 with Done in cycle 4.
